pwm_demod: RTL and testbench
============================

PWM_DEMOD -- requirements
Module: pwm_demod

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port sin  input  1  serial PWM line; period 256 clk, high for N cycles (N=0..255) from period start.
REQ-004 SHALL have port dout  output  8  last decoded duty value N.
REQ-005 SHALL have port valid  output  1  one-cycle pulse, dout updated this cycle.
REQ-006 SHALL have port locked  output  1  high once a full window has completed since reset or abort.
REQ-007 SHALL have port err  output  1  one-cycle pulse on framing error.

Function
REQ-008 SHALL sample sin through the input stage (REQ-027/028) giving sample s; rise = s high AND previous s low.
REQ-009 SHALL implement FSM states SEARCH and MEASURE; SEARCH after reset.
REQ-010 SEARCH: on rise -> MEASURE, window position pos=0, high count hc = 1 (sample at pos 0 is high).
REQ-011 MEASURE: each cycle pos increments 0..255 with 8-bit wrap; hc increments on each high sample.
REQ-012 At pos=255, the next cycle SHALL load dout with hc (including pos-255 sample), pulse valid for exactly 1 cycle, set locked, and start the next window at pos=0 with hc restarted from that cycle's sample.
REQ-013 Window restart after pos=255 SHALL occur whether or not a rise is present at new pos=0 (N=0 windows decode as 0).
REQ-014 Rise at pos != 0 in MEASURE: abort window, no valid, pulse err, clear locked, restart at pos=0 with hc=1 from this sample.
REQ-015 hc SHALL saturate at 255; a window of 256 high samples SHALL output dout=255 with valid and pulse err in the same cycle as valid.
REQ-016 dout SHALL hold its value between valid pulses.
REQ-017 Latency: valid/dout change exactly 1 clk after the pos=255 sample, plus input-stage delay.
REQ-018 Steady line in SEARCH (no rise) SHALL never produce valid or err.

Reset
REQ-019 rst_n low SHALL asynchronously force: dout=0, valid=0, locked=0, err=0, FSM=SEARCH, pos=0, hc=0, input stage cleared to 0.
REQ-020 Reset asserted mid-window SHALL discard the partial window; no valid on or after release until a new full window.
REQ-021 After release, a sin already high SHALL not count as a rise until it has been sampled low first.

Configuration
REQ-022 Macro PWM_DEMOD_SYNC_EN SHALL select the input stage.
REQ-023 Defined: sin passes a 2-flop synchronizer; input-stage delay 2 clk.
REQ-024 Undefined: sin passes a single register; input-stage delay 1 clk.
REQ-025 Decoded values, valid spacing and error behaviour SHALL be identical in both builds; only absolute latency differs by 1 clk.
REQ-026 No other functional difference SHALL depend on the macro.
REQ-027 Input stage registers SHALL be reset to 0 by rst_n.
REQ-028 Input stage SHALL feed only the rise/hc logic; sin SHALL not be used combinationally.

Verification
REQ-029 Matching 256-cycle PWM source, N=128 steady -> locked after first window; valid every 256 clk, dout=128, err never.
REQ-030 Sweep N=1,2,...,255 one period each after lock -> each valid shows dout = N of the preceding period, no err.
REQ-031 After lock switch N to 0 -> valid continues every 256 clk with dout=0, locked stays 1.
REQ-032 Phase jump: delay source by 37 clk mid-stream -> one err pulse, locked=0, aborted window gives no valid, next valid 256 clk after new rise with correct N, locked=1.
REQ-033 sin held high 600 clk after a rise -> dout=255 with valid and err same cycle.
REQ-034 rst_n low for 3 clk at pos=100 -> all outputs 0 immediately; first valid only after a full window following the next rise; run in both PWM_DEMOD_SYNC_EN builds, latency differing by 1 clk.

Source files
------------

// File: rtl/pwm_demod.sv
// PWM duty decoder: measures high time of a 256-clk PWM line, reports N per period.
// Latency: valid/dout 1 clk after the pos-255 sample plus input-stage delay (1 clk, 2 clk with sync).
// Backpressure: none; valid/err are single-cycle pulses. Build macro: PWM_DEMOD_SYNC_EN selects 2-flop sync.
`timescale 1ns/1ps
module pwm_demod (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic [7:0] dout,
  output logic       valid,
  output logic       locked,
  output logic       err
);

  typedef enum logic {SEARCH = 1'b0, MEASURE = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [7:0]  pos, pos_nxt;
  logic [7:0]  hc, hc_nxt;
  logic [7:0]  dout_nxt;
  logic        valid_nxt, err_nxt, locked_nxt;
  logic        s;       // current sample from the input stage
  logic        s_vld;   // input stage holds a real sample (not a reset value)
  logic        s_d;     // previous sample
  logic        armed;   // a genuine low sample has been seen since reset
  logic        rise;
  logic [8:0]  hc_sum;

`ifdef PWM_DEMOD_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] vld_q;
  // Two-flop synchronizer, with a matching shift of "sample is real" flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      vld_q  <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], sin};
      vld_q  <= {vld_q[0], 1'b1};
    end
  end
  assign s     = sync_q[1];
  assign s_vld = vld_q[1];
`else
  logic sin_q;
  logic vld_q;
  // Single input register, with a flag marking the first real sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      sin_q <= sin;
      vld_q <= 1'b1;
    end
  end
  assign s     = sin_q;
  assign s_vld = vld_q;
`endif

  // Previous-sample tracking; a line already high at reset release is not a rise
  // until it has been sampled low, so rise detection is armed by a real low sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d   <= 1'b0;
      armed <= 1'b0;
    end else begin
      s_d <= s;
      if (s_vld && !s) armed <= 1'b1;
    end
  end

  assign rise   = armed & s & ~s_d;
  assign hc_sum = {1'b0, hc} + {8'd0, s};

  // Next-state and output decode; pos/hc describe the sample about to be taken
  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos;
    hc_nxt     = hc;
    dout_nxt   = dout;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    locked_nxt = locked;
    case (state)
      SEARCH: begin
        if (rise) begin
          state_nxt = MEASURE;
          pos_nxt   = 8'd1;
          hc_nxt    = 8'd1;
        end
      end
      MEASURE: begin
        if (rise && pos != 8'd0) begin
          // Edge in the wrong place: drop the window and resync on this edge
          err_nxt    = 1'b1;
          locked_nxt = 1'b0;
          pos_nxt    = 8'd1;
          hc_nxt     = 8'd1;
        end else if (pos == 8'd255) begin
          // Window complete; a carry out means all 256 samples were high
          dout_nxt   = hc_sum[8] ? 8'hFF : hc_sum[7:0];
          valid_nxt  = 1'b1;
          err_nxt    = hc_sum[8];
          locked_nxt = 1'b1;
          pos_nxt    = 8'd0;
          hc_nxt     = 8'd0;
        end else begin
          pos_nxt = pos + 8'd1;
          hc_nxt  = hc_sum[8] ? 8'hFF : hc_sum[7:0];
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SEARCH;
      pos    <= 8'd0;
      hc     <= 8'd0;
      dout   <= 8'd0;
      valid  <= 1'b0;
      err    <= 1'b0;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      pos    <= pos_nxt;
      hc     <= hc_nxt;
      dout   <= dout_nxt;
      valid  <= valid_nxt;
      err    <= err_nxt;
      locked <= locked_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod: drives whole PWM periods and checks decoded values,
// valid timing, lock and error pulses. Absolute latency follows PWM_DEMOD_SYNC_EN.
`timescale 1ns/1ps
module tb_pwm_demod;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sin = 1'b0;
  logic [7:0] dout;
  logic       valid, locked, err;

  pwm_demod dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .dout(dout), .valid(valid), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

`ifdef PWM_DEMOD_SYNC_EN
  localparam int IN_DLY = 2;
`else
  localparam int IN_DLY = 1;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int vq[$];
  int tq[$];
  int eq[$];
  int errcnt = 0;
  int err_lock = -1;
  int last_start = 0;

  // Record every valid pulse and every err pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vq.push_back(int'(dout));
      tq.push_back(cyc);
      eq.push_back(int'(err));
    end
    if (err === 1'b1) begin
      errcnt++;
      err_lock = int'(locked);
    end
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      sin = v;
    end
  endtask

  // One PWM period of duty n; last_start marks the cycle its edge is driven
  task automatic period(input int n);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i == 0) last_start = cyc;
      sin = (i < n);
    end
  endtask

  task automatic clear_log();
    vq.delete();
    tq.delete();
    eq.delete();
    errcnt = 0;
    err_lock = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    if (dout !== 8'd0) begin errors++; $display("FAIL reset_dout: got %0d want 0", dout); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    drive(1'b0, 300);
    if (vq.size() != 0) begin errors++; $display("FAIL idle_valid: got %0d pulses want 0", vq.size()); end
    checks++;
    if (errcnt != 0) begin errors++; $display("FAIL idle_err: got %0d pulses want 0", errcnt); end
    checks++;
  endtask

  task automatic test_steady();
    int s0;
    do_reset();
    period(128);
    s0 = last_start;
    repeat (3) period(128);
    drive(1'b0, 4);
    if (vq.size() != 4) begin errors++; $display("FAIL steady_count: got %0d want 4", vq.size()); end
    checks++;
    for (int i = 0; i < vq.size() && i < 4; i++) begin
      if (vq[i] != 128) begin errors++; $display("FAIL steady_dout[%0d]: got %0d want 128", i, vq[i]); end
      checks++;
    end
    for (int i = 1; i < tq.size() && i < 4; i++) begin
      if (tq[i] - tq[i-1] != 256) begin errors++; $display("FAIL steady_spacing[%0d]: got %0d want 256", i, tq[i] - tq[i-1]); end
      checks++;
    end
    if (tq.size() > 0) begin
      if (tq[0] != s0 + 256 + IN_DLY) begin errors++; $display("FAIL steady_latency: got %0d want %0d", tq[0], s0 + 256 + IN_DLY); end
      checks++;
    end
    if (errcnt != 0) begin errors++; $display("FAIL steady_err: got %0d want 0", errcnt); end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL steady_locked: got %b want 1", locked); end
    checks++;
  endtask

  task automatic test_sweep();
    int nl[14] = '{1, 2, 3, 7, 15, 16, 31, 64, 100, 127, 129, 200, 254, 255};
    do_reset();
    period(128);
    for (int i = 0; i < 14; i++) period(nl[i]);
    drive(1'b0, 4);
    if (vq.size() != 15) begin errors++; $display("FAIL sweep_count: got %0d want 15", vq.size()); end
    checks++;
    if (vq.size() > 0) begin
      if (vq[0] != 128) begin errors++; $display("FAIL sweep_lock_dout: got %0d want 128", vq[0]); end
      checks++;
    end
    for (int i = 0; i < 14 && i + 1 < vq.size(); i++) begin
      if (vq[i+1] != nl[i]) begin errors++; $display("FAIL sweep_dout[%0d]: got %0d want %0d", i, vq[i+1], nl[i]); end
      checks++;
    end
    if (errcnt != 0) begin errors++; $display("FAIL sweep_err: got %0d want 0", errcnt); end
    checks++;
  endtask

  task automatic test_zero_duty();
    int want[5] = '{128, 128, 0, 0, 0};
    do_reset();
    repeat (2) period(128);
    repeat (3) period(0);
    drive(1'b0, 4);
    if (vq.size() != 5) begin errors++; $display("FAIL zero_count: got %0d want 5", vq.size()); end
    checks++;
    for (int i = 0; i < vq.size() && i < 5; i++) begin
      if (vq[i] != want[i]) begin errors++; $display("FAIL zero_dout[%0d]: got %0d want %0d", i, vq[i], want[i]); end
      checks++;
    end
    for (int i = 1; i < tq.size() && i < 5; i++) begin
      if (tq[i] - tq[i-1] != 256) begin errors++; $display("FAIL zero_spacing[%0d]: got %0d want 256", i, tq[i] - tq[i-1]); end
      checks++;
    end
    if (locked !== 1'b1) begin errors++; $display("FAIL zero_locked: got %b want 1", locked); end
    checks++;
    if (errcnt != 0) begin errors++; $display("FAIL zero_err: got %0d want 0", errcnt); end
    checks++;
  endtask

  task automatic test_phase_jump();
    int ns;
    do_reset();
    repeat (3) period(128);
    drive(1'b0, 37);
    period(128);
    ns = last_start;
    repeat (2) period(128);
    drive(1'b0, 4);
    if (vq.size() != 6) begin errors++; $display("FAIL jump_count: got %0d want 6", vq.size()); end
    checks++;
    for (int i = 0; i < vq.size() && i < 6; i++) begin
      if (vq[i] != 128) begin errors++; $display("FAIL jump_dout[%0d]: got %0d want 128", i, vq[i]); end
      checks++;
    end
    if (errcnt != 1) begin errors++; $display("FAIL jump_err_count: got %0d want 1", errcnt); end
    checks++;
    if (err_lock != 0) begin errors++; $display("FAIL jump_locked_at_err: got %0d want 0", err_lock); end
    checks++;
    if (tq.size() >= 4) begin
      if (tq[3] - tq[2] != 256 + 37) begin errors++; $display("FAIL jump_gap: got %0d want %0d", tq[3] - tq[2], 256 + 37); end
      checks++;
      if (tq[3] != ns + 256 + IN_DLY) begin errors++; $display("FAIL jump_relock_time: got %0d want %0d", tq[3], ns + 256 + IN_DLY); end
      checks++;
    end
    if (locked !== 1'b1) begin errors++; $display("FAIL jump_locked: got %b want 1", locked); end
    checks++;
  endtask

  task automatic test_saturate();
    int wv[4] = '{128, 255, 255, 88};
    int we[4] = '{0, 1, 1, 0};
    do_reset();
    period(128);
    drive(1'b1, 600);
    drive(1'b0, 300);
    if (vq.size() != 4) begin errors++; $display("FAIL sat_count: got %0d want 4", vq.size()); end
    checks++;
    for (int i = 0; i < vq.size() && i < 4; i++) begin
      if (vq[i] != wv[i]) begin errors++; $display("FAIL sat_dout[%0d]: got %0d want %0d", i, vq[i], wv[i]); end
      checks++;
      if (eq[i] != we[i]) begin errors++; $display("FAIL sat_err_with_valid[%0d]: got %0d want %0d", i, eq[i], we[i]); end
      checks++;
    end
    if (errcnt != 2) begin errors++; $display("FAIL sat_err_count: got %0d want 2", errcnt); end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked: got %b want 1", locked); end
    checks++;
  endtask

  task automatic test_reset_mid_window();
    int rs;
    do_reset();
    period(128);
    drive(1'b1, 100);
    rst_n = 1'b0;
    #1;
    if (dout !== 8'd0) begin errors++; $display("FAIL midrst_dout: got %0d want 0", dout); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL midrst_locked: got %b want 0", locked); end
    checks++;
    if (valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_pulses: got valid=%b err=%b want 0 0", valid, err); end
    checks++;
    clear_log();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 28);
    drive(1'b0, 128);
    period(128);
    rs = last_start;
    period(128);
    drive(1'b0, 4);
    if (vq.size() != 2) begin errors++; $display("FAIL midrst_count: got %0d want 2", vq.size()); end
    checks++;
    if (tq.size() > 0) begin
      if (tq[0] != rs + 256 + IN_DLY) begin errors++; $display("FAIL midrst_first_valid: got %0d want %0d", tq[0], rs + 256 + IN_DLY); end
      checks++;
    end
    for (int i = 0; i < vq.size() && i < 2; i++) begin
      if (vq[i] != 128) begin errors++; $display("FAIL midrst_dout[%0d]: got %0d want 128", i, vq[i]); end
      checks++;
    end
    if (errcnt != 0) begin errors++; $display("FAIL midrst_err: got %0d want 0", errcnt); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_sweep();
    test_zero_duty();
    test_phase_jump();
    test_saturate();
    test_reset_mid_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
